mdu_seq: RTL and testbench

- Multi-cycle unsigned multiply/divide sequencer for MULTU and DIVU.
- Owns no adder of its own: drives an external alu instance through its A/B/ALUOp ports, one iteration per clock.
  - Multiply uses ALUOp 2'b00 (add); divide uses ALUOp 2'b01 (subtract).
- Results are held in HI/LO registers that the CPU reads after done.
- Sits beside the execute stage; the CPU controller stalls while busy=1.

---
 rtl/mdu_seq.sv | 160 ++++++++++++++++
 tb/tb_mdu_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle unsigned multiply/divide sequencer (MULTU / DIVU).
//
// The block has no adder of its own. Each clock it drives one add or subtract
// through an external alu and folds the result into the HI/LO registers.
// MULTU uses shift-and-add. DIVU uses restoring shift-and-subtract.
// A request takes 32 iterations. done pulses on the 33rd cycle after start.
//
// Ports
//   clk, rstn      rising-edge clock; asynchronous active-low reset
//   start          one-cycle request, sampled only while idle
//   op             0 = MULTU, 1 = DIVU (sampled with start)
//   src_a, src_b   multiplicand/dividend, multiplier/divisor (sampled with start)
//   alu_a, alu_b   operands to the external alu
//   alu_op         2'b00 add (MUL), 2'b01 subtract (DIV), 2'b10 when idle/done
//   alu_c          result from the external alu
//   busy           high in MUL, DIV and DONE; the CPU stalls on it
//   done           one-cycle pulse; hi/lo hold the final result from this cycle
//   hi, lo         product high/low word, or remainder/quotient
//   dbg_state      current FSM state (IDLE=0, MUL=1, DIV=2, DONE=3)
//
// Handshake: start is accepted only when busy=0. Any start seen while busy=1
// is dropped and latches nothing. hi/lo are meaningful when done=1, and stay
// valid while idle until the next accepted start.
module mdu_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    input  logic [WIDTH-1:0] alu_c,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Divide step operands. The partial remainder is shifted left by one.
    // The bit shifted out of hi (ovf) means the remainder exceeds WIDTH
    // bits, so it is certainly >= the divisor.
    logic [WIDTH-1:0]   rem;
    logic               ovf;
    logic               ge;
    // Multiply step: a wrapped sum is smaller than one of its addends.
    // That gives the carry-out without a wider adder.
    logic               carry;
    logic               last_iter;

    assign rem       = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign ovf       = hi_q[WIDTH-1];
    assign ge        = ovf | (rem >= opnd_q);
    assign carry     = (alu_c < hi_q);
    assign last_iter = (cnt_q == {CNT_W{1'b1}});

    // ALU drive depends on registered state only. There is no path from
    // start/src_* to the alu.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 2'b10;
        case (state_q)
            MUL: begin
                alu_a  = hi_q;
                alu_b  = opnd_q;
                alu_op = 2'b00;
            end
            DIV: begin
                alu_a  = rem;
                alu_b  = opnd_q;
                alu_op = 2'b01;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    opnd_d  = src_b;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = src_a;
                    state_d = op ? DIV : MUL;
                end
            end
            MUL: begin
                // {hi,lo} shifts right one bit. The sum and carry come in when
                // the current multiplier bit (lo[0]) is set.
                if (lo_q[0]) begin
                    hi_d = {carry, alu_c[WIDTH-1:1]};
                    lo_d = {alu_c[0], lo_q[WIDTH-1:1]};
                end else begin
                    hi_d = {1'b0, hi_q[WIDTH-1:1]};
                    lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = DONE;
            end
            DIV: begin
                hi_d  = ge ? alu_c : rem;
                lo_d  = {lo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rstn;
  logic        start, op;
  logic [31:0] src_a, src_b;
  logic [31:0] alu_a, alu_b, alu_c;
  logic [1:0]  alu_op;
  logic        busy, done;
  logic [31:0] hi, lo;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  // external alu
  always_comb begin
    case (alu_op)
      2'b00:   alu_c = alu_a + alu_b;
      2'b01:   alu_c = alu_a - alu_b;
      default: alu_c = alu_a | alu_b;
    endcase
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  function automatic logic [63:0] model_res(input logic o, input logic [31:0] a, input logic [31:0] b);
    if (!o)            return {32'b0, a} * {32'b0, b};
    else if (b == 0)   return {a, 32'hFFFF_FFFF};
    else               return {a % b, a / b};
  endfunction

  logic [63:0] exp_q[$];
  int          left = 0;      // cycles until the request finishes; 0 = idle
  logic        m_op = 1'b0;
  logic [63:0] held = '0;     // result the outputs must hold while idle

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      left = 0;
      held = '0;
      exp_q.delete();
    end else if (left == 0) begin
      if (start === 1'b1) begin
        left = 33;
        m_op = op;
        exp_q.push_back(model_res(op, src_a, src_b));
      end
    end else begin
      left--;
      if (left == 0 && exp_q.size() > 0) held = exp_q.pop_front();
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    chk("busy", {63'b0, busy}, {63'b0, (left > 0)});
    chk("done", {63'b0, done}, {63'b0, (left == 1)});
    if (left > 1)
      chk("alu_op", {62'b0, alu_op}, {62'b0, (m_op ? 2'b01 : 2'b00)});
    else
      chk("alu_op", {62'b0, alu_op}, 64'd2);
    if (left == 0) begin
      chk("hold_hilo", {hi, lo}, held);
      chk("idle_alu_ab", {alu_a, alu_b}, 64'd0);
    end else if (left == 1) begin
      if (exp_q.size() > 0) chk("result_hilo", {hi, lo}, exp_q[0]);
      else chk("scoreboard_empty", 64'd0, 64'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
  endtask

  // Waits for done with a bound; returns cycles from start (1 = next cycle).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      n = i;
      if (done === 1'b1) break;
    end
  endtask

  task automatic run_op(input string name, input logic o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    int n;
    pulse_start(o, a, b);
    wait_done(n);
    chk({name, "_latency"}, 64'(n), 64'd33);
    chk({name, "_hi"}, {32'b0, hi}, {32'b0, eh});
    chk({name, "_lo"}, {32'b0, lo}, {32'b0, el});
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    rstn = 1'b0; start = 1'b0; op = 1'b0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy_done", {62'b0, busy, done}, 64'd0);
    #2 rstn = 1'b1;

    run_op("mul_3x5", 1'b0, 32'd3, 32'd5, 32'h0, 32'h0000_000F);
    run_op("mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mul_rand", 1'b0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080);
    run_op("div_100_7", 1'b1, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_by1", 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'd0);
    run_op("div_by0", 1'b1, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF);

    // start while busy is dropped; start in idle right after done is taken
    pulse_start(1'b0, 32'd3, 32'd5);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      n = i;
      if (done === 1'b1) break;
      if (i == 10) begin
        start = 1'b1; op = 1'b1; src_a = 32'd9; src_b = 32'd3;
      end
    end
    chk("ign_latency", 64'(n), 64'd33);
    chk("ign_hi", {32'b0, hi}, 64'd0);
    chk("ign_lo", {32'b0, lo}, 64'd15);
    run_op("div_9_3", 1'b1, 32'd9, 32'd3, 32'd0, 32'd3);

    // reset mid-divide aborts; done never pulses
    pulse_start(1'b1, 32'd100, 32'd7);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #2 rstn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_hilo", {hi, lo}, 64'd0);
      chk("abort_busy_done", {62'b0, busy, done}, 64'd0);
    end
    #2 rstn = 1'b1;
    run_op("mul_6x7", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
